// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word and shifts it out MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB.
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic load;
    logic last_bit;

    assign load     = (state_q == IDLE) && en && start;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // DONE always falls back to IDLE, even with en low, so the done pulse is one clk wide.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
`ifdef PISO_PARITY_EN
            SHIFT:   if (en && last_bit) state_d = PARITY;
            PARITY:  if (en) state_d = DONE;
`else
            SHIFT:   if (en && last_bit) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
`ifdef PISO_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d      = din;
                    cnt_d        = '0;
                    sout_d       = din[WIDTH-1];
                    sout_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
                    parity_d     = ^din;
`endif
                end
            end
            SHIFT: begin
                if (en) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef PISO_PARITY_EN
                        sout_d       = parity_q;
                        sout_valid_d = 1'b1;
`else
                        sout_d       = 1'b0;
                        sout_valid_d = 1'b0;
`endif
                    end else begin
                        sout_d       = shreg_q[WIDTH-2];
                        sout_valid_d = 1'b1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (en) begin
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b0;
                end
            end
`endif
            default: begin
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
            end
        endcase
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx (WIDTH=8); follows PISO_PARITY_EN if defined.
module tb_piso_shift_tx;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic         start;
    logic [W-1:0] din;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    int testsRun    = 0;
    int testsFailed = 0;
    int busyCycles;

    piso_shift_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .start      (start),
        .din        (din),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bit idx of the serial frame: data MSB first, then even parity.
    function automatic logic expBit(input logic [W-1:0] word, input int idx);
        if (idx < W) return word[W-1-idx];
        return ^word;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] word);
        din   = word;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called with the first bit already presented; checks the rest of the frame and the done pulse.
    task automatic runFrame(input logic [W-1:0] word, input string tag, output int nBusy);
        nBusy = 0;
        en    = 1'b1;
        for (int i = 0; i < NB; i++) begin
            checkOutput($sformatf("%s bit%0d sout", tag, i), 32'(sout), 32'(expBit(word, i)));
            checkOutput($sformatf("%s bit%0d valid", tag, i), 32'(sout_valid), 32'd1);
            checkOutput($sformatf("%s bit%0d done", tag, i), 32'(done), 32'd0);
            if (busy) nBusy++;
            tick();
        end
        checkOutput($sformatf("%s done pulse", tag), 32'(done), 32'd1);
        checkOutput($sformatf("%s done busy", tag), 32'(busy), 32'd1);
        checkOutput($sformatf("%s done valid", tag), 32'(sout_valid), 32'd0);
        checkOutput($sformatf("%s done sout", tag), 32'(sout), 32'd0);
        if (busy) nBusy++;
        tick();
        checkOutput($sformatf("%s idle done", tag), 32'(done), 32'd0);
        checkOutput($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
        checkOutput($sformatf("%s idle valid", tag), 32'(sout_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        start   = 1'b0;
        din     = '0;
        #2 reset_n = 1'b0;
        #2;
        checkOutput("reset sout", 32'(sout), 32'd0);
        checkOutput("reset valid", 32'(sout_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        tick();
        #2 reset_n = 1'b1;

        $display("[TB] frame 8'hA5");
        applyStimulus(8'hA5);
        runFrame(8'hA5, "A5", busyCycles);

        $display("[TB] frame 8'h07");
        applyStimulus(8'h07);
        runFrame(8'h07, "07", busyCycles);
        checkOutput("07 busy cycles", 32'(busyCycles), 32'(NB + 1));

        $display("[TB] en toggling, 8'hF0");
        applyStimulus(8'hF0);
        for (int c = 0; c < 2 * NB; c++) begin
            checkOutput($sformatf("F0 cyc%0d sout", c), 32'(sout), 32'(expBit(8'hF0, c / 2)));
            checkOutput($sformatf("F0 cyc%0d busy", c), 32'(busy), 32'd1);
            en = (c % 2 == 1);
            tick();
        end
        en = 1'b0;
        checkOutput("F0 done pulse", 32'(done), 32'd1);
        tick();
        checkOutput("F0 done width", 32'(done), 32'd0);
        checkOutput("F0 idle busy", 32'(busy), 32'd0);

        $display("[TB] start held, din changed mid-frame");
        applyStimulus(8'h3C);
        start = 1'b1;
        din   = 8'hFF;
        runFrame(8'h3C, "3C", busyCycles);
        tick();
        start = 1'b0;
        checkOutput("FF loaded busy", 32'(busy), 32'd1);
        runFrame(8'hFF, "FF", busyCycles);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("abort bit%0d sout", i), 32'(sout), 32'(expBit(8'hA5, i)));
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort sout", 32'(sout), 32'd0);
        checkOutput("abort valid", 32'(sout_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("abort hold%0d done", i), 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        applyStimulus(8'h81);
        runFrame(8'h81, "81", busyCycles);

        $display("[TB] start with en low");
        en    = 1'b0;
        start = 1'b1;
        din   = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("enlow%0d busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("enlow%0d valid", i), 32'(sout_valid), 32'd0);
        end
        en = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("enhigh load busy", 32'(busy), 32'd1);
        runFrame(8'hC3, "C3", busyCycles);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
